// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding, default timing and width helper for button autorepeat
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_WAIT_REL = 2'd2
    } btn_state_t;

    localparam int DEF_INITIAL_HOLD  = 300;
    localparam int DEF_REPEAT_PERIOD = 150;
    localparam int DEF_FAST_PERIOD   = 50;
    localparam int DEF_FAST_AFTER    = 4;
    localparam int DEF_CNT_W         = 12;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_first_set.sv
// rtl/prio_first_set.sv - combinational lowest-index-set encoder with valid flag
module prio_first_set #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                vld = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/btn_autorepeat_multi.sv
// rtl/btn_autorepeat_multi.sv - multi-channel button autorepeat with first-press channel locking
module btn_autorepeat_multi
    import btn_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int INITIAL_HOLD  = DEF_INITIAL_HOLD,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int FAST_PERIOD   = DEF_FAST_PERIOD,
    parameter int FAST_AFTER    = DEF_FAST_AFTER,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic              clk_100mhz,
    input  logic              rst_btn,
    input  logic              tick_1khz,
    input  logic [NUM_CH-1:0] btn_in,
    input  logic [NUM_CH-1:0] repeat_en,
    output logic [NUM_CH-1:0] pulse_out,
    output logic              busy,
    output logic [2:0]        active_ch,
    output logic              fast_mode
);

    localparam int IDX_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int REP_W = (FAST_AFTER > 0) ? clog2(FAST_AFTER + 1) : 1;
    localparam logic [CNT_W-1:0] H_FIRST = CNT_W'(INITIAL_HOLD);
    localparam logic [CNT_W-1:0] H_WRAP  = CNT_W'(INITIAL_HOLD + REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] H_FAST  = CNT_W'(FAST_PERIOD);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(FAST_AFTER);

    btn_state_t        state;
    logic [IDX_W-1:0]  owner;
    logic [CNT_W-1:0]  h;
    logic [CNT_W-1:0]  h_inc;
    logic [REP_W-1:0]  rep;
    logic              any_vld;
    logic [IDX_W-1:0]  first_idx;
    logic [NUM_CH-1:0] others_mask;
    logic              owner_held;
    logic              rep_on;

    prio_first_set #(
        .N     (NUM_CH),
        .IDX_W (IDX_W)
    ) u_prio (
        .req (btn_in),
        .vld (any_vld),
        .idx (first_idx)
    );

    always_comb begin
        others_mask        = btn_in;
        others_mask[owner] = 1'b0;
    end

    assign owner_held = btn_in[owner];
    assign rep_on     = repeat_en[owner];
    assign h_inc      = (h == '1) ? h : h + 1'b1;

    // Slow phase keeps h within INITIAL_HOLD+REPEAT_PERIOD by rewinding one
    // period at each slow repeat point; fast phase counts from 0 per pulse.
    always_ff @(posedge clk_100mhz) begin
        if (rst_btn) begin
            state     <= ST_IDLE;
            owner     <= '0;
            h         <= '0;
            rep       <= '0;
            pulse_out <= '0;
            busy      <= 1'b0;
            active_ch <= '0;
            fast_mode <= 1'b0;
        end else begin
            pulse_out <= '0;
            if (tick_1khz) begin
                case (state)
                    ST_IDLE: begin
                        if (any_vld) begin
                            owner                <= first_idx;
                            active_ch            <= 3'(first_idx);
                            pulse_out[first_idx] <= 1'b1;
                            h                    <= '0;
                            rep                  <= '0;
                            fast_mode            <= 1'b0;
                            busy                 <= 1'b1;
                            state                <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (!owner_held) begin
                            h         <= '0;
                            rep       <= '0;
                            fast_mode <= 1'b0;
                            if (|others_mask) begin
                                state <= ST_WAIT_REL;
                            end else begin
                                state     <= ST_IDLE;
                                busy      <= 1'b0;
                                active_ch <= '0;
                            end
                        end else if (fast_mode) begin
                            if (h_inc == H_FAST) begin
                                h <= '0;
                                if (rep_on) begin
                                    pulse_out[owner] <= 1'b1;
                                end
                            end else begin
                                h <= h_inc;
                            end
                        end else if ((h_inc == H_FIRST) || (h_inc == H_WRAP)) begin
                            if (rep_on) begin
                                pulse_out[owner] <= 1'b1;
                                if (rep != REP_MAX) begin
                                    rep <= rep + 1'b1;
                                end
                            end
                            if (rep_on && (FAST_AFTER > 0) && (rep + 1'b1 == REP_MAX)) begin
                                fast_mode <= 1'b1;
                                h         <= '0;
                            end else begin
                                h <= (h_inc == H_WRAP) ? H_FIRST : h_inc;
                            end
                        end else begin
                            h <= h_inc;
                        end
                    end
                    ST_WAIT_REL: begin
                        if (!(|btn_in)) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            active_ch <= '0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/btn_autorepeat_multi.md
Name: btn_autorepeat_multi

Overview:
Parametrised successor to the single-button autorepeat logic feeding rpm_ctrl. Converts NUM_CH debounced button levels into one-clock step pulses: one pulse on press, then repeats after an initial hold delay, then accelerates to a faster repeat period. Adds per-channel single-shot/repeat mode and first-press channel locking so that simultaneous or overlapping presses never interleave. Sits between the debouncer/synchroniser and rpm_ctrl, clocked at 100 MHz and evaluated on the 1 kHz tick.

Parameters:
NUM_CH, 2, number of button channels (1..8)
INITIAL_HOLD, 300, ticks from press to the first repeat pulse
REPEAT_PERIOD, 150, ticks between slow repeats
FAST_PERIOD, 50, ticks between fast repeats (must be >=1 and <= REPEAT_PERIOD)
FAST_AFTER, 4, slow repeats before switching to FAST_PERIOD; 0 disables acceleration
CNT_W, 12, hold counter width; must hold INITIAL_HOLD + REPEAT_PERIOD

Ports:
clk_100mhz  in  1  system clock; single clock domain
rst_btn  in  1  synchronous reset, active-high
tick_1khz  in  1  one-clk-wide enable, 1 kHz
btn_in  in  NUM_CH  debounced, synchronised button levels, 1 = pressed
repeat_en  in  NUM_CH  per-channel mode: 1 = autorepeat, 0 = single-shot
pulse_out  out  NUM_CH  one-clk step pulse per channel
busy  out  1  a channel owns the unit (HOLD or WAIT_REL)
active_ch  out  3  index of owning channel; 0 when idle
fast_mode  out  1  owner is repeating at FAST_PERIOD

Behaviour:
- Reset (synchronous, rst_btn=1 on a clk edge): state=IDLE; all counters 0; pulse_out=0, busy=0, active_ch=0, fast_mode=0. Reset overrides tick in the same cycle.
- All state transitions and counting occur only in cycles with tick_1khz=1. pulse_out is registered: it asserts in the clk cycle after the evaluating tick, for exactly one clk, with at most one bit set.
- Hold counter h: set to 0 on the press tick, +1 on every later tick while the owner is held.
- IDLE: on a tick with any btn_in bit set, owner = lowest set index; pulse owner; h=0; rep=0; go to HOLD. Simultaneous presses: lowest index wins, the others are ignored.
- HOLD, owner still pressed on a tick: h+1. If repeat_en[owner]=1:
  - slow phase: pulse when h = INITIAL_HOLD + k*REPEAT_PERIOD (k>=0), then rep+1.
  - once rep = FAST_AFTER (FAST_AFTER>0): fast_mode=1, and subsequent pulses every FAST_PERIOD ticks after the last slow pulse.
  - rep saturates at FAST_AFTER.
  - If repeat_en[owner]=0, no further pulses. repeat_en is sampled every tick, so dropping it mid-hold stops repeats immediately.
- HOLD, owner released on a tick: if any other btn_in bit is set, go to WAIT_REL; otherwise go to IDLE. Either way clear h, rep and fast_mode.
- WAIT_REL: no pulses. Return to IDLE on the first tick with btn_in all 0. A channel held across the ownership change never generates a pulse without a fresh press.
- Pulse count for a hold of H ticks (H>=1, repeat on, no acceleration): 1 + ceil(max(0, H - INITIAL_HOLD) / REPEAT_PERIOD).
- Reset mid-hold: outputs return to 0 immediately. A button still held after reset is treated as a new press on the next tick.
- h saturates at its maximum. In fast phase, h restarts from 0 after each fast pulse, so there is no wrap-around.

Decomposition:
- Shared package btn_pkg holds:
  - state encoding: IDLE, HOLD, WAIT_REL (2 bits)
  - default timing constants: INITIAL_HOLD, REPEAT_PERIOD, FAST_PERIOD, FAST_AFTER
  - function clog2 for counter widths
- One sub-module, prio_first_set: combinational lowest-index-set encoder returning a valid flag and an index. It is natural because it is reused by the future gear-switch arbiter.
- Counter and FSM stay in btn_autorepeat_multi.

Test Plan:
- ch0 held 50 ticks, defaults -> exactly 1 pulse on pulse_out[0], one clk after the press tick; busy drops after release.
- ch0 held 700 ticks, FAST_AFTER=0 -> 4 pulses at h=0,300,450,600; fast_mode stays 0.
- ch0 held 700 ticks, FAST_AFTER=2, FAST_PERIOD=50 -> 7 pulses at h=0,300,450,500,550,600,650; fast_mode=1 from h=450 until release.
- ch0 and ch1 pressed on the same tick, held 320 ticks -> 2 pulses, all on ch0, none on ch1. Then release ch0 with ch1 held -> state WAIT_REL, no ch1 pulse; release ch1 and re-press -> 1 ch1 pulse.
- repeat_en[1]=0, ch1 held 700 ticks -> exactly 1 pulse; active_ch=1 and busy=1 throughout the hold.
- rst_btn asserted for 1 clk at h=350 during a ch0 hold -> outputs 0 the next clk; ch0 still held -> new press pulse on the next tick, and the next repeat at h=300 measured from that tick.
